// File: rtl/vga_timing_if.sv
// Video timing bundle: pixel strobe, syncs, blanking, counters and frame marker.
// The generator drives it through the master modport; pixel logic uses the slave modport.
interface vga_timing_if;
  logic       pixel_clk;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       sync;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;

  modport master (
    output pixel_clk, hs, vs, blank, sync, DrawX, DrawY, frame_start
  );

  modport slave (
    input pixel_clk, hs, vs, blank, sync, DrawX, DrawY, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe at Clk/2, registered syncs/blank kept coherent
// with the DrawX/DrawY counters, and a one-cycle frame_start on each wrap to (0,0).
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic         Clk,
  input  logic         Reset,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: line and frame totals must not exceed 1024");
  end

  localparam logic [9:0]  HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VLast   = 10'(V_TOTAL - 1);
  // 11-bit bounds so an end value of exactly 1024 does not truncate to 0
  localparam logic [10:0] HsStart = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HsEnd   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VsStart = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VsEnd   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] HVis    = 11'(H_VISIBLE);
  localparam logic [10:0] VVis    = 11'(V_VISIBLE);

  logic       pix_en_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    if (pix_en_q) begin
      if (x_q == HLast) begin
        x_d = '0;
        if (y_q == VLast) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Decode from the next counter values so the registered flags line up with them
    hs_d    = !(({1'b0, x_d} >= HsStart) && ({1'b0, x_d} < HsEnd));
    vs_d    = !(({1'b0, y_d} >= VsStart) && ({1'b0, y_d} < VsEnd));
    blank_d = ({1'b0, x_d} < HVis) && ({1'b0, y_d} < VVis);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= ~pix_en_q;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_clk   = pix_en_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank       = blank_q;
  assign vga.sync        = 1'b0;
  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance for line-level checks and a shrunken
// instance for frame-level checks, both compared against a closed-form raster model.
module tb_vga_timing_gen;

  localparam int unsigned SmHv = 20, SmHf = 4, SmHs = 6, SmHb = 5;
  localparam int unsigned SmVv = 12, SmVf = 2, SmVs = 3, SmVb = 4;
  localparam int unsigned SmHt = SmHv + SmHf + SmHs + SmHb;  // 35
  localparam int unsigned SmVt = SmVv + SmVf + SmVs + SmVb;  // 21
  localparam int unsigned SmFrame = 2 * SmHt * SmVt;         // 1470 Clk cycles

  typedef struct packed {
    logic       pclk;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  logic            Clk;
  logic            Reset;
  longint unsigned n_edges;  // Clk edges since Reset was last released
  int              checks;
  int              errors;

  vga_timing_if vif_def ();
  vga_timing_if vif_sm ();

  vga_timing_gen u_dut_def (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (vif_def)
  );

  vga_timing_gen #(
    .H_VISIBLE (SmHv), .H_FRONT (SmHf), .H_SYNC (SmHs), .H_BACK (SmHb),
    .V_VISIBLE (SmVv), .V_FRONT (SmVf), .V_SYNC (SmVs), .V_BACK (SmVb)
  ) u_dut_sm (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (vif_sm)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  // Raster position after n edges: one advance per two edges, starting from (0,0).
  function automatic exp_t model(longint unsigned n, int unsigned hv, int unsigned hf,
                                 int unsigned hsw, int unsigned hb, int unsigned vv,
                                 int unsigned vf, int unsigned vsw, int unsigned vb);
    exp_t m;
    longint unsigned ht, vt, adv, x, y;
    ht  = hv + hf + hsw + hb;
    vt  = vv + vf + vsw + vb;
    adv = n / 2;
    x   = adv % ht;
    y   = (adv / ht) % vt;
    m.pclk  = n[0];
    m.hs    = !(x >= hv + hf && x < hv + hf + hsw);
    m.vs    = !(y >= vv + vf && y < vv + vf + vsw);
    m.blank = (x < hv) && (y < vv);
    m.fs    = (n != 0) && (n % 2 == 0) && (adv % (ht * vt) == 0);
    m.x     = 10'(x);
    m.y     = 10'(y);
    return m;
  endfunction

  function automatic exp_t exp_def(longint unsigned n);
    return model(n, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic exp_t exp_sm(longint unsigned n);
    return model(n, SmHv, SmHf, SmHs, SmHb, SmVv, SmVf, SmVs, SmVb);
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] got_def, got_sm;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    got_def = {vif_def.pixel_clk, vif_def.hs, vif_def.vs, vif_def.blank, vif_def.sync,
               vif_def.frame_start, vif_def.DrawX, vif_def.DrawY};
    got_sm  = {vif_sm.pixel_clk, vif_sm.hs, vif_sm.vs, vif_sm.blank, vif_sm.sync,
               vif_sm.frame_start, vif_sm.DrawX, vif_sm.DrawY};
    checks++;
    if (got_def !== 26'b0_1_1_1_0_0_0000000000_0000000000) begin
      errors++;
      $display("FAIL reset_def: got %h expected %h", got_def, 26'b0_1_1_1_0_0_0_0);
    end
    checks++;
    if (got_sm !== 26'b0_1_1_1_0_0_0000000000_0000000000) begin
      errors++;
      $display("FAIL reset_sm: got %h expected %h", got_sm, 26'b0_1_1_1_0_0_0_0);
    end
  endtask

  task automatic test_startup();
    int exp_pclk[4] = '{1, 0, 1, 0};
    int exp_x[4]    = '{0, 1, 1, 2};
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++;
      if (vif_def.pixel_clk !== 1'(exp_pclk[i]) || vif_def.DrawX !== 10'(exp_x[i])) begin
        errors++;
        $display("FAIL startup edge %0d: got pclk=%b x=%0d expected pclk=%0d x=%0d",
                 i + 1, vif_def.pixel_clk, vif_def.DrawX, exp_pclk[i], exp_x[i]);
      end
    end
  endtask

  task automatic test_hsync();
    int         low_cnt = 0;
    bit         saw_fall = 0, saw_rise = 0;
    logic [9:0] prev_x;
    logic       prev_hs;
    do_reset();
    prev_x  = vif_def.DrawX;
    prev_hs = vif_def.hs;
    for (int i = 0; i < 1700; i++) begin
      @(negedge Clk);
      if (vif_def.DrawY == 10'd0 && vif_def.hs === 1'b0) low_cnt++;
      if (prev_x == 10'd655 && vif_def.DrawX == 10'd656) begin
        saw_fall = 1;
        checks++;
        if (!(prev_hs === 1'b1 && vif_def.hs === 1'b0)) begin
          errors++;
          $display("FAIL hs_fall: got hs %b->%b expected 1->0", prev_hs, vif_def.hs);
        end
      end
      if (prev_x == 10'd751 && vif_def.DrawX == 10'd752) begin
        saw_rise = 1;
        checks++;
        if (!(prev_hs === 1'b0 && vif_def.hs === 1'b1)) begin
          errors++;
          $display("FAIL hs_rise: got hs %b->%b expected 0->1", prev_hs, vif_def.hs);
        end
      end
      prev_x  = vif_def.DrawX;
      prev_hs = vif_def.hs;
    end
    checks++;
    if (!(saw_fall && saw_rise)) begin
      errors++;
      $display("FAIL hs_edges_seen: got fall=%0d rise=%0d expected 1 1", saw_fall, saw_rise);
    end
    checks++;
    if (low_cnt != 192) begin
      errors++;
      $display("FAIL hs_low_cycles: got %0d expected 192", low_cnt);
    end
  endtask

  task automatic test_line_wrap();
    bit found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge Clk);
      if (vif_def.DrawX == 10'd799 && vif_def.DrawY == 10'd10) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL line_wrap_reach: got no (799,10) expected it within 20000 cycles");
    end else begin
      for (int i = 0; i < 4 && vif_def.DrawX == 10'd799; i++) @(negedge Clk);
      checks++;
      if (vif_def.DrawX !== 10'd0 || vif_def.DrawY !== 10'd11) begin
        errors++;
        $display("FAIL line_wrap: got (%0d,%0d) expected (0,11)", vif_def.DrawX, vif_def.DrawY);
      end
    end
  endtask

  task automatic test_blank();
    int seen_a = 0, seen_b = 0, seen_c = 0;
    do_reset();
    for (int i = 0; i < SmFrame + 10; i++) begin
      @(negedge Clk);
      if (vif_sm.DrawX == 10'(SmHv - 1) && vif_sm.DrawY == 10'(SmVv - 1)) begin
        seen_a++;
        checks++;
        if (vif_sm.blank !== 1'b1) begin
          errors++;
          $display("FAIL blank_last_visible: got %b expected 1", vif_sm.blank);
        end
      end
      if (vif_sm.DrawX == 10'(SmHv) && vif_sm.DrawY == 10'(SmVv - 1)) begin
        seen_b++;
        checks++;
        if (vif_sm.blank !== 1'b0) begin
          errors++;
          $display("FAIL blank_hporch: got %b expected 0", vif_sm.blank);
        end
      end
      if (vif_sm.DrawX == 10'd0 && vif_sm.DrawY == 10'(SmVv)) begin
        seen_c++;
        checks++;
        if (vif_sm.blank !== 1'b0) begin
          errors++;
          $display("FAIL blank_vporch: got %b expected 0", vif_sm.blank);
        end
      end
    end
    checks++;
    if (seen_a == 0 || seen_b == 0 || seen_c == 0) begin
      errors++;
      $display("FAIL blank_corners_seen: got %0d %0d %0d expected all nonzero",
               seen_a, seen_b, seen_c);
    end
  endtask

  task automatic test_frames();
    int vs_low = 0, pulses = 0, first_k = 0, second_k = 0;
    do_reset();
    for (int k = 1; k <= 2 * SmFrame + 20; k++) begin
      @(negedge Clk);
      if (vif_sm.vs === 1'b0) begin
        vs_low++;
        if (vif_sm.DrawY < 10'(SmVv + SmVf) || vif_sm.DrawY >= 10'(SmVv + SmVf + SmVs)) begin
          checks++;
          errors++;
          $display("FAIL vs_line: got vs=0 at y=%0d expected y in %0d..%0d", vif_sm.DrawY,
                   SmVv + SmVf, SmVv + SmVf + SmVs - 1);
        end
      end
      if (vif_sm.frame_start === 1'b1) begin
        pulses++;
        if (pulses == 1) first_k = k;
        if (pulses == 2) second_k = k;
        checks++;
        if (vif_sm.DrawX !== 10'd0 || vif_sm.DrawY !== 10'd0) begin
          errors++;
          $display("FAIL fs_origin: got (%0d,%0d) expected (0,0)", vif_sm.DrawX, vif_sm.DrawY);
        end
      end
    end
    checks++;
    if (vs_low != 2 * 2 * SmHt * SmVs) begin
      errors++;
      $display("FAIL vs_low_cycles: got %0d expected %0d", vs_low, 2 * 2 * SmHt * SmVs);
    end
    checks++;
    if (pulses != 2 || first_k != SmFrame || second_k - first_k != SmFrame) begin
      errors++;
      $display("FAIL fs_period: got pulses=%0d at %0d,%0d expected 2 at %0d,%0d", pulses,
               first_k, second_k, SmFrame, 2 * SmFrame);
    end
  endtask

  task automatic test_async_reset();
    logic [25:0] got;
    int          pulses = 0, pulse_k = 0;
    repeat ($urandom_range(300, 1300)) @(negedge Clk);
    #3 Reset = 1'b1;
    #1;
    got = {vif_sm.pixel_clk, vif_sm.hs, vif_sm.vs, vif_sm.blank, vif_sm.sync,
           vif_sm.frame_start, vif_sm.DrawX, vif_sm.DrawY};
    checks++;
    if (got !== 26'b0_1_1_1_0_0_0000000000_0000000000) begin
      errors++;
      $display("FAIL async_reset_sm: got %h expected %h", got, 26'b0_1_1_1_0_0_0_0);
    end
    got = {vif_def.pixel_clk, vif_def.hs, vif_def.vs, vif_def.blank, vif_def.sync,
           vif_def.frame_start, vif_def.DrawX, vif_def.DrawY};
    checks++;
    if (got !== 26'b0_1_1_1_0_0_0000000000_0000000000) begin
      errors++;
      $display("FAIL async_reset_def: got %h expected %h", got, 26'b0_1_1_1_0_0_0_0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 1; k <= SmFrame + 4; k++) begin
      @(negedge Clk);
      if (k <= 2) begin
        checks++;
        if (vif_sm.pixel_clk !== (k == 1) || vif_sm.DrawX !== 10'(k - 1)) begin
          errors++;
          $display("FAIL post_reset edge %0d: got pclk=%b x=%0d expected pclk=%0d x=%0d", k,
                   vif_sm.pixel_clk, vif_sm.DrawX, k == 1, k - 1);
        end
      end
      if (vif_sm.frame_start === 1'b1) begin
        pulses++;
        pulse_k = k;
      end
    end
    checks++;
    if (pulses != 1 || pulse_k != SmFrame) begin
      errors++;
      $display("FAIL post_reset_fs: got %0d pulses, last at %0d expected 1 at %0d", pulses,
               pulse_k, SmFrame);
    end
  endtask

  task automatic test_random();
    exp_t e, a;
    for (int it = 0; it < 5; it++) begin
      repeat ($urandom_range(200, 2500)) begin
        @(negedge Clk);
        e = exp_sm(n_edges);
        a = {vif_sm.pixel_clk, vif_sm.hs, vif_sm.vs, vif_sm.blank, vif_sm.frame_start,
             vif_sm.DrawX, vif_sm.DrawY};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL rand_sm n=%0d: got p%b h%b v%b b%b f%b (%0d,%0d) expected p%b h%b v%b b%b f%b (%0d,%0d)",
                   n_edges, a.pclk, a.hs, a.vs, a.blank, a.fs, a.x, a.y,
                   e.pclk, e.hs, e.vs, e.blank, e.fs, e.x, e.y);
        end
        e = exp_def(n_edges);
        a = {vif_def.pixel_clk, vif_def.hs, vif_def.vs, vif_def.blank, vif_def.frame_start,
             vif_def.DrawX, vif_def.DrawY};
        checks++;
        if (a !== e || vif_def.sync !== 1'b0) begin
          errors++;
          $display("FAIL rand_def n=%0d: got p%b h%b v%b b%b f%b s%b (%0d,%0d) expected p%b h%b v%b b%b f%b s0 (%0d,%0d)",
                   n_edges, a.pclk, a.hs, a.vs, a.blank, a.fs, vif_def.sync, a.x, a.y,
                   e.pclk, e.hs, e.vs, e.blank, e.fs, e.x, e.y);
        end
      end
      // Occasionally restart from an arbitrary point within the Clk period
      if ($urandom_range(0, 1) == 1) begin
        #($urandom_range(1, 8));
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    test_reset();
    test_startup();
    test_hsync();
    test_line_wrap();
    test_blank();
    test_frames();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
